// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Parses the byte stream coming out of the UART RX core into a framed
//   record of NUM_FIELDS fields:  SOF, NUM_FIELDS payload bytes,
//   [XOR checksum], EOF. Only a complete, valid frame updates `fields`,
//   and that update is flagged by a one-cycle `load` pulse. A frame that
//   stalls for TIMEOUT_CYC cycles between bytes, or carries a bad checksum
//   or a bad EOF byte, is aborted: `frame_err` pulses and `err_cnt`
//   increments (saturating at 8'hFF).
//
//   Optional feature macro: UART_FRAME_CHECKSUM_EN
//     defined   -> a checksum byte (XOR of the full 8-bit payload bytes)
//                  is expected between the last field and EOF.
//     undefined -> EOF follows the last field directly.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   rx_dv      in   one-cycle strobe: rx_byte is valid
//   rx_byte    in   [7:0] received byte
//   fields     out  [NUM_FIELDS*FIELD_W-1:0] accepted fields, field 0 in LSBs
//   load       out  one-cycle pulse: fields updated
//   frame_err  out  one-cycle pulse: frame aborted
//   busy       out  high while a frame is in progress
//   err_cnt    out  [7:0] aborted-frame count, saturating
module uart_frame_rx #(
  parameter int         NUM_FIELDS  = 3,
  parameter int         FIELD_W     = 6,
  parameter logic [7:0] SOF_BYTE    = 8'hFF,
  parameter logic [7:0] EOF_BYTE    = 8'hFF,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_dv,
  input  logic [7:0]                    rx_byte,
  output logic [NUM_FIELDS*FIELD_W-1:0] fields,
  output logic                          load,
  output logic                          frame_err,
  output logic                          busy,
  output logic [7:0]                    err_cnt
);

  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

`ifdef UART_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_FIELD, ST_CHK, ST_EOF} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FIELD, ST_EOF} state_t;
`endif

  state_t                          state;
  state_t                          state_nxt;
  logic [IDX_W-1:0]                idx;
  logic [TMR_W-1:0]                timer;
  logic [NUM_FIELDS*FIELD_W-1:0]   shadow;
  logic                            start;
  logic                            store;
  logic                            do_load;
  logic                            do_abort;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]                      acc;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next-state and per-cycle decisions
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    store     = 1'b0;
    do_load   = 1'b0;
    do_abort  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_dv && rx_byte == SOF_BYTE) begin
          state_nxt = ST_FIELD;
          start     = 1'b1;
        end
      end
      ST_FIELD: begin
        // A payload byte equal to SOF_BYTE is plain data here.
        if (rx_dv) begin
          store = 1'b1;
          if (idx == LAST_IDX) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_nxt = ST_CHK;
`else
            state_nxt = ST_EOF;
`endif
          end
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      ST_CHK: begin
        if (rx_dv) begin
          if (rx_byte == acc) state_nxt = ST_EOF;
          else                do_abort  = 1'b1;
        end
      end
`endif
      ST_EOF: begin
        if (rx_dv) begin
          if (rx_byte == EOF_BYTE) begin
            do_load   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            do_abort  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A byte arriving on the last allowed cycle wins over the timeout.
    if (state != ST_IDLE && !rx_dv && timer == TMR_LAST) do_abort = 1'b1;
    if (do_abort) state_nxt = ST_IDLE;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state != ST_IDLE);

  // Datapath, counters and output pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fields    <= '0;
      shadow    <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'h00;
      idx       <= '0;
      timer     <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      acc       <= 8'h00;
`endif
    end else begin
      load      <= do_load;
      frame_err <= do_abort;
      if (do_abort) err_cnt <= sat_inc8(err_cnt);
      if (do_load)  fields  <= shadow;

      if (start)                          idx <= '0;
      else if (store && idx != LAST_IDX)  idx <= idx + 1'b1;

      if (store) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          if (idx == IDX_W'(i)) shadow[i*FIELD_W +: FIELD_W] <= rx_byte[FIELD_W-1:0];
        end
      end

      // Timer only runs inside a frame and restarts on every byte.
      if (state == ST_IDLE || rx_dv || do_abort) timer <= '0;
      else                                       timer <= timer + 1'b1;

`ifdef UART_FRAME_CHECKSUM_EN
      if (start)      acc <= 8'h00;
      else if (store) acc <= acc ^ rx_byte;
`endif
    end
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Parametrised successor of the clock-setting UART receiver: parses a byte stream from the UART RX core into a framed record of NUM_FIELDS fields.
- Frame format: SOF byte, NUM_FIELDS payload bytes, optional XOR checksum byte, EOF byte.
- Only complete, valid frames update the output fields; the update is marked by a one-cycle load pulse.
- Adds an inter-byte timeout and error reporting, which the previous generation lacked. Sits between the UART RX core and the clock/alarm registers.

Parameters:
- NUM_FIELDS, 3, number of payload bytes per frame (1..8); default order is hours, minutes, seconds.
- FIELD_W, 6, bits kept per field (1..8); lower FIELD_W bits of each payload byte.
- SOF_BYTE, 8'hFF, start-of-frame marker.
- EOF_BYTE, 8'hFF, end-of-frame marker.
- TIMEOUT_CYC, 1000000, max clock cycles between bytes inside a frame; must be ≥ 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_dv  in  1  one-cycle strobe from the UART RX core: rx_byte is valid.
- rx_byte  in  8  received byte.
- fields  out  NUM_FIELDS*FIELD_W  accepted field values; field 0 in the LSBs.
- load  out  1  one-cycle pulse: fields were updated this cycle.
- frame_err  out  1  one-cycle pulse: frame aborted.
- busy  out  1  high while a frame is in progress (state ≠ IDLE).
- err_cnt  out  8  count of aborted frames; saturates at 8'hFF.

Behaviour:
- Reset (reset=0, asynchronous) clears: fields, load, frame_err, err_cnt, shadow registers, field index, timeout counter, checksum accumulator. State goes to IDLE.
- All outputs are registered. Nothing happens on cycles where rx_dv=0, except the timeout counter.
- IDLE:
  - rx_dv with rx_byte==SOF_BYTE → FIELD; idx=0, accumulator=0, timer=0.
  - Any other byte is ignored silently: no error, no count.
- FIELD:
  - On rx_dv: shadow[idx] <= rx_byte[FIELD_W-1:0] (upper bits truncated); acc ^= rx_byte.
  - If idx==NUM_FIELDS-1: go to CHK if CHECKSUM_EN is defined, else EOF. Otherwise idx+1.
  - A payload byte equal to SOF_BYTE is treated as data; no resync.
- CHK: on rx_dv, rx_byte==acc → EOF; else abort.
- EOF:
  - On rx_dv with rx_byte==EOF_BYTE: at that same edge, fields <= shadow, load=1 for one cycle, state → IDLE.
  - Any other byte → abort.
- Abort: frame_err=1 for one cycle, err_cnt+1 (saturating), state → IDLE, fields unchanged.
- Timeout:
  - Outside IDLE, timer increments each cycle and clears on each rx_dv.
  - If timer reaches TIMEOUT_CYC-1 with no rx_dv → abort.
  - If rx_dv arrives in that same cycle, the byte wins and no abort occurs.
- Latency: load rises at the first edge after the EOF byte's rx_dv cycle; that is, load is high in the cycle after rx_dv.
- A new SOF may arrive the cycle after load or frame_err; it is accepted normally.
- Reset mid-frame discards the shadow contents; fields reads 0.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- Defined: a CHK state is inserted after the last field. The expected byte is the XOR of all NUM_FIELDS full 8-bit payload bytes; a mismatch aborts the frame.
- Undefined: no CHK state, no accumulator logic; EOF follows the last field directly.

Test Plan:
- Default params, macro off: send FF,0x0C,0x1E,0x2D,FF → one load pulse; fields={6'h2D,6'h1E,6'h0C}; frame_err stays 0.
- Bad EOF: FF,01,02,03,0x55 → frame_err pulse; err_cnt=1; fields unchanged; next valid frame still loads.
- Timeout with TIMEOUT_CYC=16: FF,01 then idle 16 cycles → frame_err pulse, busy=0. Repeat with a byte arriving on cycle 15 → no abort.
- Macro on: FF,0x0C,0x1E,0x2D,0x3F,FF → load. Same frame with checksum 0x3E → frame_err, err_cnt+1.
- Noise in IDLE (0x00, 0x41, 0xFE) → no busy, no frame_err. Async reset asserted mid-frame after 2 fields → outputs 0 immediately, state IDLE.
- Saturation: 260 bad frames → err_cnt holds 8'hFF. Truncation: FIELD_W=5, payload 0xFF → field=5'h1F.
